// File: rtl/cc_miss_req_scheduler.sv
// Miss request scheduler: accepts one cache miss at a time, issues one 8x64-bit WRAP AR per miss
// and pushes the miss address to the fill FIFO. Optional stats counters under CC_MISS_STATS_EN.
module cc_miss_req_scheduler #(
   parameter int MAX_OUTST = 4,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             miss_req_valid_i,
   input  logic [31:0]      miss_req_addr_i,
   output logic             miss_req_ready_o,
   output logic             mem_arvalid_o,
   input  logic             mem_arready_i,
   output logic [31:0]      mem_araddr_o,
   output logic [3:0]       mem_arlen_o,
   output logic [2:0]       mem_arsize_o,
   output logic [1:0]       mem_arburst_o,
   input  logic             mem_rvalid_i,
   input  logic             mem_rready_i,
   input  logic             mem_rlast_i,
   input  logic             miss_addr_fifo_full_i,
   output logic             miss_addr_fifo_wren_o,
   output logic [31:0]      miss_addr_fifo_wdata_o,
   output logic [CNT_W-1:0] outst_cnt_o,
   output logic             underflow_o,
`ifdef CC_MISS_STATS_EN
   output logic [15:0]      stat_miss_cnt_o,
   output logic [15:0]      stat_stall_cnt_o,
`endif
   output logic             dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // once raised, arvalid and araddr stay stable until that edge.

   typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_OUTST);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_arvalid;
   logic             r_wren;
   logic [31:0]      r_addr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_underflow;
   logic             w_ready;
   logic             w_accept;
   logic             w_ar_hs;
   logic             w_rlast;

   assign w_accept = miss_req_valid_i && w_ready;
   assign w_ar_hs  = r_arvalid && mem_arready_i;
   assign w_rlast  = mem_rvalid_i && mem_rready_i && mem_rlast_i;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // The full flag only matters at accept; the FIFO reserves a slot once it reports !full.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = (r_cnt < LP_MAX) && !miss_addr_fifo_full_i;
            if (miss_req_valid_i && w_ready) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (w_ar_hs) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_arvalid <= 1'b0;
         r_wren    <= 1'b0;
         r_addr    <= 32'd0;
      end else begin
         r_wren <= w_accept;
         if (w_accept) begin
            r_addr    <= miss_req_addr_i;
            r_arvalid <= 1'b1;
         end else if (w_ar_hs) begin
            r_arvalid <= 1'b0;
         end
      end
   end

   // Accept and rlast together cancel out, so an rlast paired with an accept never underflows.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_underflow <= 1'b0;
      end else begin
         case ({w_accept, w_rlast})
            2'b10: r_cnt <= r_cnt + CNT_W'(1);
            2'b01: begin
               if (r_cnt == '0) r_underflow <= 1'b1;
               else             r_cnt       <= r_cnt - CNT_W'(1);
            end
            default: r_cnt <= r_cnt;
         endcase
      end
   end

`ifdef CC_MISS_STATS_EN
   logic [15:0] r_stat_miss;
   logic [15:0] r_stat_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_miss  <= 16'd0;
         r_stat_stall <= 16'd0;
      end else begin
         if (w_ar_hs && (r_stat_miss != 16'hFFFF)) r_stat_miss <= r_stat_miss + 16'd1;
         if (miss_req_valid_i && !w_ready && (r_stat_stall != 16'hFFFF))
            r_stat_stall <= r_stat_stall + 16'd1;
      end
   end

   assign stat_miss_cnt_o  = r_stat_miss;
   assign stat_stall_cnt_o = r_stat_stall;
`endif

   assign miss_req_ready_o       = w_ready;
   assign mem_arvalid_o          = r_arvalid;
   assign mem_araddr_o           = {r_addr[31:3], 3'b000};
   assign mem_arlen_o            = 4'd7;
   assign mem_arsize_o           = 3'd3;
   assign mem_arburst_o          = 2'b10;
   assign miss_addr_fifo_wren_o  = r_wren;
   assign miss_addr_fifo_wdata_o = r_addr;
   assign outst_cnt_o            = r_cnt;
   assign underflow_o            = r_underflow;
   assign dbg_state_o            = (r_state == S_REQ);

endmodule

// File: tb/tb_cc_miss_req_scheduler.sv
// Bench for cc_miss_req_scheduler: directed scenarios with literal checks plus randomized traffic
// compared every cycle against a queue-based model of the refill rules.
module tb_cc_miss_req_scheduler;
  localparam int MAX = 4;
  localparam int CW  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          valid, arready, rvalid, rready, rlast, full;
  logic [31:0]   addr;
  logic          ready, arvalid, wren, underflow, dbg_state;
  logic [31:0]   araddr, wdata;
  logic [3:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [CW-1:0] outst;
`ifdef CC_MISS_STATS_EN
  logic [15:0]   stat_miss, stat_stall;
`endif

  cc_miss_req_scheduler #(.MAX_OUTST(MAX), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req_valid_i(valid), .miss_req_addr_i(addr), .miss_req_ready_o(ready),
    .mem_arvalid_o(arvalid), .mem_arready_i(arready), .mem_araddr_o(araddr),
    .mem_arlen_o(arlen), .mem_arsize_o(arsize), .mem_arburst_o(arburst),
    .mem_rvalid_i(rvalid), .mem_rready_i(rready), .mem_rlast_i(rlast),
    .miss_addr_fifo_full_i(full), .miss_addr_fifo_wren_o(wren),
    .miss_addr_fifo_wdata_o(wdata), .outst_cnt_o(outst), .underflow_o(underflow),
`ifdef CC_MISS_STATS_EN
    .stat_miss_cnt_o(stat_miss), .stat_stall_cnt_o(stat_stall),
`endif
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];   // FIFO pushes expected in the next cycle
  logic [31:0] ar_q[$];    // misses whose AR has not yet been accepted
  int          m_outst = 0;
  bit          m_uf    = 0;
  logic [31:0] m_last  = '0;
`ifdef CC_MISS_STATS_EN
  int          m_smiss  = 0;
  int          m_sstall = 0;
`endif

  function automatic bit m_ready();
    return (ar_q.size() == 0) && (m_outst < MAX) && !full;
  endfunction

  always @(posedge clk) begin
    bit acc, hs, rl;
    if (!rst_n) begin
      exp_q.delete(); ar_q.delete();
      m_outst = 0; m_uf = 0; m_last = '0;
`ifdef CC_MISS_STATS_EN
      m_smiss = 0; m_sstall = 0;
`endif
    end else begin
      acc = valid && m_ready();
      hs  = (ar_q.size() != 0) && arready;
      rl  = rvalid && rready && rlast;
`ifdef CC_MISS_STATS_EN
      if (hs && m_smiss < 16'hFFFF) m_smiss++;
      if (valid && !m_ready() && m_sstall < 16'hFFFF) m_sstall++;
`endif
      if (hs) void'(ar_q.pop_front());
      if (acc) begin
        ar_q.push_back(addr);
        exp_q.push_back(addr);
        m_last = addr;
      end
      if (acc && !rl) m_outst++;
      else if (rl && !acc) begin
        if (m_outst == 0) m_uf = 1;
        else m_outst--;
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    logic [31:0] w;
    chk("ready", ready, m_ready());
    chk("arvalid", arvalid, ar_q.size() != 0);
    chk("araddr", araddr, {m_last[31:3], 3'b000});
    chk("wren", wren, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("wdata", wdata, w);
    end
    chk("outst", outst, m_outst);
    chk("underflow", underflow, m_uf);
    chk("state", dbg_state, ar_q.size() != 0);
    chk("arlen", arlen, 4'd7);
    chk("arsize", arsize, 3'd3);
    chk("arburst", arburst, 2'b10);
`ifdef CC_MISS_STATS_EN
    chk("stat_miss", stat_miss, m_smiss);
    chk("stat_stall", stat_stall, m_sstall);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic r_beats(input int n);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    int n_acc;
    rst_n = 1'b0; valid = 1'b0; addr = '0; arready = 1'b0;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; full = 1'b0;
    repeat (3) cyc();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wren", wren, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_outst", outst, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    cyc();

    // single miss, arready two cycles late, then an 8-beat burst
    valid = 1'b1; addr = 32'h0001_2368;
    #1 chk("t1_ready", ready, 1);
    cyc();
    valid = 1'b0; addr = '0;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_wren", wren, 1);
    chk("t1_wdata", wdata, 32'h0001_2368);
    chk("t1_araddr", araddr, 32'h0001_2368);
    chk("t1_len_size_burst", {arlen, arsize, arburst}, {4'd7, 3'd3, 2'd2});
    chk("t1_outst", outst, 1);
    cyc();
    chk("t1_wren_once", wren, 0);
    chk("t1_ar_hold", arvalid, 1);
    cyc();
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    chk("t1_ar_done", arvalid, 0);
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1; rready = 1'b1; rlast = (i == 7);
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0;
    chk("t1_outst_end", outst, 0);

    // five back-to-back misses with arready high: throttled at four
    arready = 1'b1; valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      addr = $urandom;
      #1 if (ready) n_acc++;
      cyc();
    end
    chk("t2_accepts", n_acc, 4);
    chk("t2_outst", outst, 4);
    #1 chk("t2_ready_low", ready, 0);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    cyc();
    rvalid = 1'b0; rlast = 1'b0;
    #1 chk("t2_fifth_ready", ready, 1);
    cyc();
    valid = 1'b0;
    chk("t2_outst_after", outst, 4);
    cyc();
    r_beats(4);
    chk("t2_drained", outst, 0);

    // FIFO full blocks acceptance
    full = 1'b1; valid = 1'b1; addr = 32'hDEAD_BEE8;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_ready_full", ready, 0);
      cyc();
      chk("t3_no_push", wren, 0);
      chk("t3_no_ar", arvalid, 0);
    end
    full = 1'b0;
    #1 chk("t3_ready_free", ready, 1);
    cyc();
    valid = 1'b0;
    chk("t3_push", wren, 1);
    chk("t3_wdata", wdata, 32'hDEAD_BEE8);
    cyc();

    // accept and rlast in the same cycle at outst=2
    valid = 1'b1; addr = 32'h0000_1000;
    cyc();
    valid = 1'b0;
    cyc();
    chk("t4_outst_pre", outst, 2);
    valid = 1'b1; addr = 32'h0000_2008;
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    #1 chk("t4_ready", ready, 1);
    cyc();
    valid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    chk("t4_outst_same", outst, 2);
    cyc();
    r_beats(2);
    chk("t4_drained", outst, 0);

    // rlast with nothing outstanding
    r_beats(1);
    chk("t5_outst", outst, 0);
    chk("t5_underflow", underflow, 1);
    repeat (5) cyc();
    chk("t5_sticky", underflow, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t5_cleared", underflow, 0);

    // reset while an AR is pending
    arready = 1'b0; valid = 1'b1; addr = 32'h0BAD_F00D;
    cyc();
    valid = 1'b0;
    chk("t6_arvalid_pre", arvalid, 1);
    rst_n = 1'b0;
    cyc();
    chk("t6_arvalid", arvalid, 0);
    chk("t6_outst", outst, 0);
    chk("t6_state", dbg_state, 0);
    chk("t6_wren", wren, 0);
`ifdef CC_MISS_STATS_EN
    chk("t6_stat_miss", stat_miss, 0);
    chk("t6_stat_stall", stat_stall, 0);
`endif
    rst_n = 1'b1;
    cyc();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      valid   = ($urandom_range(0, 2) != 0);
      addr    = $urandom;
      arready = ($urandom_range(0, 2) == 0);
      full    = ($urandom_range(0, 4) == 0);
      rvalid  = ($urandom_range(0, 1) == 1);
      rready  = ($urandom_range(0, 3) != 0);
      rlast   = ($urandom_range(0, 3) == 0);
      cyc();
    end
    valid = 1'b0; rvalid = 1'b0; rlast = 1'b0; full = 1'b0; arready = 1'b1; rst_n = 1'b1;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
